// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline front end.
package mips_pkg;

  localparam int          INSTR_W        = 32;
  localparam logic [31:0] NOP            = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;
  localparam int          PC_INC         = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem access, pipeline control inputs and the IF/ID view
// handed to decode. master = fetch unit, slave = surrounding pipeline.
interface fetch_unit_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] instr_rdata;
  logic              stall;
  logic              redirect;
  logic [DATA_W-1:0] redirect_target;
  logic              exception;
  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] if_id_pc;
  logic [DATA_W-1:0] if_id_pc4;
  logic [DATA_W-1:0] if_id_instr;
  logic              if_id_valid;
  logic              misalign;

  modport master (
    input  instr_rdata, stall, redirect, redirect_target, exception,
    output imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign
  );

  modport slave (
    output instr_rdata, stall, redirect, redirect_target, exception,
    input  imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign
  );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures the
// fetched instruction, otherwise contents hold (stall).
module if_id_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] pc4_in,
  input  logic [DATA_W-1:0] instr_in,
  output logic [DATA_W-1:0] pc_r,
  output logic [DATA_W-1:0] pc4_r,
  output logic [DATA_W-1:0] instr_r,
  output logic              valid_r
);

  localparam logic [DATA_W-1:0] BUBBLE_INSTR = DATA_W'(NOP);

  // Pipeline register with async clear; flush beats load beats hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r    <= {DATA_W{1'b0}};
      pc4_r   <= {DATA_W{1'b0}};
      instr_r <= BUBBLE_INSTR;
      valid_r <= 1'b0;
    end else if (flush) begin
      pc_r    <= {DATA_W{1'b0}};
      pc4_r   <= {DATA_W{1'b0}};
      instr_r <= BUBBLE_INSTR;
      valid_r <= 1'b0;
    end else if (load) begin
      pc_r    <= pc_in;
      pc4_r   <= pc4_in;
      instr_r <= instr_in;
      valid_r <= 1'b1;
    end else begin
      pc_r    <= pc_r;
      pc4_r   <= pc4_r;
      instr_r <= instr_r;
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC priority mux
// (exception > redirect > stall > sequential) and the misalign pulse flop.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_PC   = DATA_W'(DEF_RESET_PC),
  parameter logic [DATA_W-1:0] EXC_VECTOR = DATA_W'(DEF_EXC_VECTOR)
) (
  input logic              clk,
  input logic              reset,
  fetch_unit_if.master     bus
);

  logic [DATA_W-1:0] pc_r;
  logic [DATA_W-1:0] pc_plus4_s;
  logic [DATA_W-1:0] next_pc_s;
  logic              misalign_r;
  logic              misalign_next_s;
  logic              flush_s;
  logic              load_s;
  logic [DATA_W-1:0] if_id_pc_s;
  logic [DATA_W-1:0] if_id_pc4_s;
  logic [DATA_W-1:0] if_id_instr_s;
  logic              if_id_valid_s;

  // Sequential increment wraps naturally modulo 2^DATA_W.
  assign pc_plus4_s = pc_r + DATA_W'(PC_INC);
  assign flush_s    = bus.exception | bus.redirect;
  assign load_s     = ~bus.stall;

  // Next-PC priority mux and misalign detection of the redirect target.
  always_comb begin
    next_pc_s       = pc_r;
    misalign_next_s = 1'b0;
    if (bus.exception) begin
      next_pc_s       = EXC_VECTOR;
      misalign_next_s = 1'b0;
    end else if (bus.redirect) begin
      // Low bits are dropped so the PC stays word-aligned.
      next_pc_s       = {bus.redirect_target[DATA_W-1:2], 2'b00};
      misalign_next_s = (bus.redirect_target[1:0] != 2'b00);
    end else if (bus.stall) begin
      next_pc_s       = pc_r;
      misalign_next_s = 1'b0;
    end else begin
      next_pc_s       = pc_plus4_s;
      misalign_next_s = 1'b0;
    end
  end

  // PC and misalign registers with async active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r       <= RESET_PC;
      misalign_r <= 1'b0;
    end else begin
      pc_r       <= next_pc_s;
      misalign_r <= misalign_next_s;
    end
  end

  if_id_reg #(
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .flush    (flush_s),
    .pc_in    (pc_r),
    .pc4_in   (pc_plus4_s),
    .instr_in (bus.instr_rdata),
    .pc_r     (if_id_pc_s),
    .pc4_r    (if_id_pc4_s),
    .instr_r  (if_id_instr_s),
    .valid_r  (if_id_valid_s)
  );

  assign bus.imem_addr   = pc_r;
  assign bus.if_id_pc    = if_id_pc_s;
  assign bus.if_id_pc4   = if_id_pc4_s;
  assign bus.if_id_instr = if_id_instr_s;
  assign bus.if_id_valid = if_id_valid_s;
  assign bus.misalign    = misalign_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fetch_unit_if #(.DATA_W(32)) bus ();

  fetch_unit #(
    .DATA_W     (32),
    .RESET_PC   (32'h0000_0000),
    .EXC_VECTOR (32'h8000_0180)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Instruction memory contents as seen by the bench.
  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    if (addr == 32'h0000_0000) return 32'h2008_0005;
    else return 32'hAC00_0000 ^ addr;
  endfunction

  assign bus.instr_rdata = instr_of(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic st, input logic rd, input logic [31:0] tgt, input logic ex);
    bus.stall           = st;
    bus.redirect        = rd;
    bus.redirect_target = tgt;
    bus.exception       = ex;
  endtask

  task automatic test_reset();
    set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    #12;
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=%h", bus.imem_addr, 32'h0); end
    checks++; if (bus.if_id_pc !== 32'h0) begin failures++; $display("FAIL reset_if_id_pc got=%h exp=%h", bus.if_id_pc, 32'h0); end
    checks++; if (bus.if_id_pc4 !== 32'h0) begin failures++; $display("FAIL reset_if_id_pc4 got=%h exp=%h", bus.if_id_pc4, 32'h0); end
    checks++; if (bus.if_id_instr !== 32'h0) begin failures++; $display("FAIL reset_if_id_instr got=%h exp=%h", bus.if_id_instr, 32'h0); end
    checks++; if (bus.if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.if_id_valid); end
    checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_release();
    tick();
    checks++; if (bus.if_id_pc !== 32'h0) begin failures++; $display("FAIL rel_if_id_pc got=%h exp=%h", bus.if_id_pc, 32'h0); end
    checks++; if (bus.if_id_pc4 !== 32'h4) begin failures++; $display("FAIL rel_if_id_pc4 got=%h exp=%h", bus.if_id_pc4, 32'h4); end
    checks++; if (bus.if_id_instr !== 32'h2008_0005) begin failures++; $display("FAIL rel_if_id_instr got=%h exp=%h", bus.if_id_instr, 32'h2008_0005); end
    checks++; if (bus.if_id_valid !== 1'b1) begin failures++; $display("FAIL rel_valid got=%b exp=1", bus.if_id_valid); end
    checks++; if (bus.imem_addr !== 32'h4) begin failures++; $display("FAIL rel_imem_addr got=%h exp=%h", bus.imem_addr, 32'h4); end
  endtask

  task automatic test_stall();
    tick();
    checks++; if (bus.if_id_pc !== 32'h4) begin failures++; $display("FAIL seq2_if_id_pc got=%h exp=%h", bus.if_id_pc, 32'h4); end
    tick();
    checks++; if (bus.imem_addr !== 32'hC) begin failures++; $display("FAIL seq3_imem_addr got=%h exp=%h", bus.imem_addr, 32'hC); end
    set_ctl(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.imem_addr !== 32'hC) begin failures++; $display("FAIL stall_imem_addr[%0d] got=%h exp=%h", i, bus.imem_addr, 32'hC); end
      checks++; if (bus.if_id_pc !== 32'h8) begin failures++; $display("FAIL stall_if_id_pc[%0d] got=%h exp=%h", i, bus.if_id_pc, 32'h8); end
      checks++; if (bus.if_id_pc4 !== 32'hC) begin failures++; $display("FAIL stall_if_id_pc4[%0d] got=%h exp=%h", i, bus.if_id_pc4, 32'hC); end
      checks++; if (bus.if_id_instr !== 32'hAC00_0008) begin failures++; $display("FAIL stall_if_id_instr[%0d] got=%h exp=%h", i, bus.if_id_instr, 32'hAC00_0008); end
      checks++; if (bus.if_id_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, bus.if_id_valid); end
    end
    set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checks++; if (bus.if_id_pc !== 32'hC) begin failures++; $display("FAIL resume_if_id_pc got=%h exp=%h", bus.if_id_pc, 32'hC); end
    checks++; if (bus.if_id_instr !== 32'hAC00_000C) begin failures++; $display("FAIL resume_if_id_instr got=%h exp=%h", bus.if_id_instr, 32'hAC00_000C); end
    checks++; if (bus.imem_addr !== 32'h10) begin failures++; $display("FAIL resume_imem_addr got=%h exp=%h", bus.imem_addr, 32'h10); end
  endtask

  task automatic test_redirect();
    set_ctl(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    tick();
    checks++; if (bus.imem_addr !== 32'h40) begin failures++; $display("FAIL redir_imem_addr got=%h exp=%h", bus.imem_addr, 32'h40); end
    checks++; if (bus.if_id_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", bus.if_id_valid); end
    checks++; if (bus.if_id_instr !== 32'h0) begin failures++; $display("FAIL redir_instr got=%h exp=%h", bus.if_id_instr, 32'h0); end
    checks++; if (bus.if_id_pc !== 32'h0) begin failures++; $display("FAIL redir_if_id_pc got=%h exp=%h", bus.if_id_pc, 32'h0); end
    checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL redir_misalign got=%b exp=0", bus.misalign); end
    set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checks++; if (bus.if_id_pc !== 32'h40) begin failures++; $display("FAIL redir2_if_id_pc got=%h exp=%h", bus.if_id_pc, 32'h40); end
    checks++; if (bus.if_id_valid !== 1'b1) begin failures++; $display("FAIL redir2_valid got=%b exp=1", bus.if_id_valid); end
    checks++; if (bus.if_id_instr !== 32'hAC00_0040) begin failures++; $display("FAIL redir2_instr got=%h exp=%h", bus.if_id_instr, 32'hAC00_0040); end
    checks++; if (bus.imem_addr !== 32'h44) begin failures++; $display("FAIL redir2_imem_addr got=%h exp=%h", bus.imem_addr, 32'h44); end
  endtask

  task automatic test_redirect_stall();
    set_ctl(1'b1, 1'b1, 32'h0000_0102, 1'b0);
    tick();
    checks++; if (bus.imem_addr !== 32'h100) begin failures++; $display("FAIL rs_imem_addr got=%h exp=%h", bus.imem_addr, 32'h100); end
    checks++; if (bus.misalign !== 1'b1) begin failures++; $display("FAIL rs_misalign got=%b exp=1", bus.misalign); end
    checks++; if (bus.if_id_valid !== 1'b0) begin failures++; $display("FAIL rs_valid got=%b exp=0", bus.if_id_valid); end
    set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL rs_misalign_pulse got=%b exp=0", bus.misalign); end
    checks++; if (bus.if_id_pc !== 32'h100) begin failures++; $display("FAIL rs_if_id_pc got=%h exp=%h", bus.if_id_pc, 32'h100); end
  endtask

  task automatic test_back_to_back();
    set_ctl(1'b0, 1'b1, 32'h0000_0203, 1'b0);
    tick();
    checks++; if (bus.misalign !== 1'b1) begin failures++; $display("FAIL b2b_misalign0 got=%b exp=1", bus.misalign); end
    checks++; if (bus.imem_addr !== 32'h200) begin failures++; $display("FAIL b2b_imem0 got=%h exp=%h", bus.imem_addr, 32'h200); end
    set_ctl(1'b0, 1'b1, 32'h0000_0301, 1'b0);
    tick();
    checks++; if (bus.misalign !== 1'b1) begin failures++; $display("FAIL b2b_misalign1 got=%b exp=1", bus.misalign); end
    checks++; if (bus.imem_addr !== 32'h300) begin failures++; $display("FAIL b2b_imem1 got=%h exp=%h", bus.imem_addr, 32'h300); end
    set_ctl(1'b0, 1'b1, 32'h0000_0400, 1'b0);
    tick();
    checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL b2b_misalign2 got=%b exp=0", bus.misalign); end
    checks++; if (bus.if_id_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid got=%b exp=0", bus.if_id_valid); end
    set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_exception();
    set_ctl(1'b1, 1'b1, 32'h0000_0042, 1'b1);
    tick();
    checks++; if (bus.imem_addr !== 32'h8000_0180) begin failures++; $display("FAIL exc_imem_addr got=%h exp=%h", bus.imem_addr, 32'h8000_0180); end
    checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL exc_misalign got=%b exp=0", bus.misalign); end
    checks++; if (bus.if_id_valid !== 1'b0) begin failures++; $display("FAIL exc_valid got=%b exp=0", bus.if_id_valid); end
    checks++; if (bus.if_id_instr !== 32'h0) begin failures++; $display("FAIL exc_instr got=%h exp=%h", bus.if_id_instr, 32'h0); end
    set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checks++; if (bus.if_id_pc !== 32'h8000_0180) begin failures++; $display("FAIL exc2_if_id_pc got=%h exp=%h", bus.if_id_pc, 32'h8000_0180); end
    checks++; if (bus.if_id_pc4 !== 32'h8000_0184) begin failures++; $display("FAIL exc2_if_id_pc4 got=%h exp=%h", bus.if_id_pc4, 32'h8000_0184); end
  endtask

  task automatic test_wrap_and_reset();
    set_ctl(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_imem0 got=%h exp=%h", bus.imem_addr, 32'hFFFF_FFFC); end
    set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checks++; if (bus.if_id_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_if_id_pc got=%h exp=%h", bus.if_id_pc, 32'hFFFF_FFFC); end
    checks++; if (bus.if_id_pc4 !== 32'h0) begin failures++; $display("FAIL wrap_if_id_pc4 got=%h exp=%h", bus.if_id_pc4, 32'h0); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_imem1 got=%h exp=%h", bus.imem_addr, 32'h0); end
    checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL wrap_misalign got=%b exp=0", bus.misalign); end
    // Mid-cycle reset with a redirect pending.
    set_ctl(1'b1, 1'b1, 32'h0000_0083, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL mid_reset_imem got=%h exp=%h", bus.imem_addr, 32'h0); end
    checks++; if (bus.if_id_pc !== 32'h0) begin failures++; $display("FAIL mid_reset_if_id_pc got=%h exp=%h", bus.if_id_pc, 32'h0); end
    checks++; if (bus.if_id_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", bus.if_id_valid); end
    checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL mid_reset_misalign got=%b exp=0", bus.misalign); end
    tick();
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL held_reset_imem got=%h exp=%h", bus.imem_addr, 32'h0); end
    set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (bus.if_id_pc !== 32'h0) begin failures++; $display("FAIL post_reset_if_id_pc got=%h exp=%h", bus.if_id_pc, 32'h0); end
    checks++; if (bus.if_id_instr !== 32'h2008_0005) begin failures++; $display("FAIL post_reset_instr got=%h exp=%h", bus.if_id_instr, 32'h2008_0005); end
    checks++; if (bus.imem_addr !== 32'h4) begin failures++; $display("FAIL post_reset_imem got=%h exp=%h", bus.imem_addr, 32'h4); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_release();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_exception();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end of the MIPS pipeline. Holds the program counter and drives the instruction-memory address. Captures the fetched word into the IF/ID pipeline register consumed by decode. Supports stall, branch/jump redirect with flush, and an exception vector, and flags misaligned redirect targets.

Parameters:
DATA_W, 32, width of PC and instruction words
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h8000_0180, PC value loaded on exception

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-low reset
instr_rdata  input  DATA_W  instruction word from imem; combinational read of imem_addr, same cycle
stall  input  1  hazard unit: hold PC and IF/ID contents
redirect  input  1  branch taken / jump / jr: load redirect_target and flush IF/ID
redirect_target  input  DATA_W  next PC when redirect=1
exception  input  1  trap: load EXC_VECTOR and flush IF/ID
imem_addr  output  DATA_W  current PC; combinational copy of PC register
if_id_pc  output  DATA_W  PC of the instruction held in IF/ID
if_id_pc4  output  DATA_W  if_id_pc + 4 (link/branch base)
if_id_instr  output  DATA_W  instruction held in IF/ID
if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
misalign  output  1  one-cycle pulse: last redirect target had addr[1:0] != 0

Behaviour:
- Reset (reset=0, async, takes effect immediately): pc=RESET_PC; if_id_pc=0, if_id_pc4=0, if_id_instr=NOP (32'h0), if_id_valid=0, misalign=0.
- Reset release: first rising edge with reset=1 and no stall captures {RESET_PC, RESET_PC+4, instr_rdata} into IF/ID, sets valid=1, and sets pc=RESET_PC+4.
- Per rising edge, priority highest first:
  1. exception=1: pc<=EXC_VECTOR; IF/ID<=bubble (pc/pc4=0, instr=NOP, valid=0); misalign<=0. Overrides redirect and stall.
  2. redirect=1: pc<={redirect_target[31:2],2'b00}; IF/ID<=bubble; misalign<=(redirect_target[1:0]!=0). Overrides stall.
  3. stall=1: pc and all IF/ID fields hold; misalign<=0.
  4. otherwise: pc<=pc+4; IF/ID<={pc, pc+4, instr_rdata, valid=1}; misalign<=0.
- Arithmetic: pc+4 is modulo 2^DATA_W. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Latency: fetch-to-IF/ID is one cycle. Redirect produces exactly one bubble in IF/ID; the target instruction appears in IF/ID on the second edge after redirect.
- misalign is registered and high for exactly one cycle per misaligned redirect. Back-to-back misaligned redirects keep it high.
- pc[1:0] is always 00.
- Reset asserted mid-stall or mid-redirect: async clear wins. No pending redirect is remembered.
- stall and redirect never combine to drop a redirect; a redirect is consumed in the cycle it is asserted.

Decomposition:
- Package mips_pkg holds:
  - INSTR_W = 32
  - NOP = 32'h0000_0000
  - RESET_PC and EXC_VECTOR default constants
  - PC_INC = 4
- One sub-module, if_id_reg: IF/ID pipeline register with load-enable (= !stall or flush), flush-to-bubble, and async active-low clear.
- fetch_unit owns the PC register, the next-PC priority mux and the misalign flop.

Test Plan:
- Reset release, instr_rdata=32'h2008_0005 at PC 0, no stall -> after edge 1: if_id_pc=0, if_id_pc4=4, if_id_instr=32'h2008_0005, valid=1, imem_addr=4.
- Sequential run 3 cycles, then stall=1 for 2 cycles -> imem_addr stays 32'h0000_000C and IF/ID stays {8, C, instr@8, valid=1}. Resumes at 0xC after stall drops.
- redirect=1, target=32'h0000_0040, at PC 0x10 -> next edge: imem_addr=0x40, valid=0, instr=NOP. Following edge: if_id_pc=0x40, valid=1.
- redirect and stall together, target=32'h0000_0102 -> pc=0x100, misalign=1 for one cycle, IF/ID bubble.
- exception together with redirect (target 0x40) -> pc=32'h8000_0180, misalign=0, IF/ID bubble.
- Force pc to 32'hFFFF_FFFC via redirect, then run 1 cycle -> if_id_pc=FFFF_FFFC, if_id_pc4=0, imem_addr=0. Then assert reset mid-cycle -> all outputs at reset values immediately.
